// File: rtl/smi_pkg.sv
// Shared SMI definitions: address map, byte-lane order and prefetch states.
// The byte order is shared with the write-path assembler so host loopback is lossless.
package smi_pkg;

   localparam logic [2:0] SmiAddrIdle     = 3'b000;
   localparam logic [2:0] SmiAddrWrite900  = 3'b001;
   localparam logic [2:0] SmiAddrWrite2400 = 3'b010;
   localparam logic [2:0] SmiAddrRead900   = 3'b101;
   localparam logic [2:0] SmiAddrRead2400  = 3'b110;

   // Byte lane sent for byte index 0..3 (lane n = word[8n+7:8n]).
   localparam logic [1:0] SmiLaneIdx0 = 2'd2;
   localparam logic [1:0] SmiLaneIdx1 = 2'd3;
   localparam logic [1:0] SmiLaneIdx2 = 2'd0;
   localparam logic [1:0] SmiLaneIdx3 = 2'd1;

   typedef enum logic [1:0] {
      PfEmpty,
      PfPending,
      PfFull
   } pf_state_e;

   function automatic logic [7:0] smi_byte_sel(input logic [31:0] word, input logic [1:0] idx);
      logic [1:0] lane;
      unique case (idx)
         2'd0:    lane = SmiLaneIdx0;
         2'd1:    lane = SmiLaneIdx1;
         2'd2:    lane = SmiLaneIdx2;
         default: lane = SmiLaneIdx3;
      endcase
      unique case (lane)
         2'd0:    return word[7:0];
         2'd1:    return word[15:8];
         2'd2:    return word[23:16];
         default: return word[31:24];
      endcase
   endfunction

endpackage

// File: rtl/smi_tx_serializer_if.sv
// SMI host bus and RX FIFO read port seen by the TX serializer.
interface smi_tx_serializer_if;

   logic [2:0]  i_smi_a;
   logic        i_smi_soe_se;
   logic [7:0]  o_smi_data_out;
   logic        o_smi_read_req;
   logic        o_fifo_pull;
   logic [31:0] i_fifo_pulled_data;
   logic        i_fifo_empty;

   modport master (
      input  i_smi_a,
      input  i_smi_soe_se,
      output o_smi_data_out,
      output o_smi_read_req,
      output o_fifo_pull,
      input  i_fifo_pulled_data,
      input  i_fifo_empty
   );

   modport slave (
      output i_smi_a,
      output i_smi_soe_se,
      input  o_smi_data_out,
      input  o_smi_read_req,
      input  o_fifo_pull,
      output i_fifo_pulled_data,
      output i_fifo_empty
   );

endinterface

// File: rtl/smi_strobe_sync.sv
// N-stage synchroniser for an active-low async strobe plus a falling-edge pulse.
// All flops reset to 1 so an idle-high strobe never produces a spurious pulse.
module smi_strobe_sync #(
   parameter int unsigned P_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_strobe_n,
   output logic o_fall
);

   logic [P_STAGES-1:0] r_sync;
   logic                r_last;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sync <= '1;
         r_last <= 1'b1;
      end else begin
         r_sync <= {r_sync[P_STAGES-2:0], i_strobe_n};
         r_last <= r_sync[P_STAGES-1];
      end
   end

   assign o_fall = r_last & ~r_sync[P_STAGES-1];

endmodule

// File: rtl/smi_tx_serializer.sv
// SMI read path: prefetches 32-bit RX FIFO words and emits one byte per host SOE strobe,
// with an underrun flag, a counter test mode and a registered DREQ.
module smi_tx_serializer
   import smi_pkg::*;
#(
   parameter logic [2:0]  P_READ_ADDR   = SmiAddrRead900,
   parameter int unsigned P_SYNC_STAGES = 2
) (
   input  logic                        i_sys_clk,
   input  logic                        i_reset_n,
   input  logic                        i_smi_test,
   input  logic                        i_underrun_clr,
   output logic                        o_underrun,
   smi_tx_serializer_if.master         if_smi
);

   logic        w_fall;
   logic        w_strobe;
   logic        w_underrun;
   logic        w_last;
   logic        w_handoff;

   logic [2:0]  r_addr;
   logic [31:0] r_act_word;
   logic        r_act_valid;
   logic [1:0]  r_act_idx;
   logic [31:0] r_pf_word;
   pf_state_e   r_pf_state;
   logic        r_fifo_pull;
   logic [7:0]  r_data_out;
   logic        r_read_req;
   logic        r_underrun;
   logic [7:0]  r_test_cnt;

   smi_strobe_sync #(
      .P_STAGES (P_SYNC_STAGES)
   ) u_soe_sync (
      .i_clk      (i_sys_clk),
      .i_reset_n  (i_reset_n),
      .i_strobe_n (if_smi.i_smi_soe_se),
      .o_fall     (w_fall)
   );

   assign w_strobe   = w_fall && (r_addr == P_READ_ADDR);
   assign w_underrun = w_strobe && !i_smi_test && !r_act_valid;
   assign w_last     = w_strobe && !i_smi_test && r_act_valid && (r_act_idx == 2'd3);
   // Test mode freezes both word registers, so no hand-off either.
   assign w_handoff  = !i_smi_test && (!r_act_valid || w_last);

   always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_addr      <= SmiAddrIdle;
         r_act_word  <= '0;
         r_act_valid <= 1'b0;
         r_act_idx   <= 2'd0;
         r_pf_word   <= '0;
         r_pf_state  <= PfEmpty;
         r_fifo_pull <= 1'b0;
         r_data_out  <= 8'h00;
         r_read_req  <= 1'b0;
         r_underrun  <= 1'b0;
         r_test_cnt  <= 8'h00;
      end else begin
         r_addr      <= if_smi.i_smi_a;
         r_fifo_pull <= 1'b0;

         if (w_strobe) begin
            if (i_smi_test) begin
               r_data_out <= r_test_cnt;
               r_test_cnt <= r_test_cnt + 8'd1;
            end else if (r_act_valid) begin
               r_data_out <= smi_byte_sel(r_act_word, r_act_idx);
               r_act_idx  <= r_act_idx + 2'd1;
               if (r_act_idx == 2'd3) r_act_valid <= 1'b0;
            end else begin
               r_data_out <= 8'h00;
            end
         end

         if (w_underrun) begin
            r_underrun <= 1'b1;
         end else if (i_underrun_clr) begin
            r_underrun <= 1'b0;
         end

         // Hand-off below overrides the valid clear above on a last-byte consume.
         unique case (r_pf_state)
            PfEmpty: begin
               if (!if_smi.i_fifo_empty && !i_smi_test) begin
                  r_fifo_pull <= 1'b1;
                  r_pf_state  <= PfPending;
               end
            end
            PfPending: begin
               r_pf_word  <= if_smi.i_fifo_pulled_data;
               r_pf_state <= PfFull;
            end
            PfFull: begin
               if (w_handoff) begin
                  r_act_word  <= r_pf_word;
                  r_act_idx   <= 2'd0;
                  r_act_valid <= 1'b1;
                  r_pf_state  <= PfEmpty;
               end
            end
            default: r_pf_state <= PfEmpty;
         endcase

         r_read_req <= !i_smi_test && (r_act_valid || (r_pf_state == PfFull));
      end
   end

   assign if_smi.o_fifo_pull    = r_fifo_pull;
   assign if_smi.o_smi_data_out = r_data_out;
   assign if_smi.o_smi_read_req = r_read_req;
   assign o_underrun            = r_underrun;

endmodule

// File: tb/tb_smi_tx_serializer.sv
// Directed bench for smi_tx_serializer: byte order, streaming, underrun, test mode,
// address filtering and asynchronous reset, against hand-computed bytes.
module tb_smi_tx_serializer;
   import smi_pkg::*;

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic smi_test = 1'b0;
   logic uclr     = 1'b0;
   logic underrun;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   smi_tx_serializer_if bus ();

   smi_tx_serializer #(
      .P_READ_ADDR   (3'b101),
      .P_SYNC_STAGES (2)
   ) dut (
      .i_sys_clk      (clk),
      .i_reset_n      (rst_n),
      .i_smi_test     (smi_test),
      .i_underrun_clr (uclr),
      .o_underrun     (underrun),
      .if_smi         (bus)
   );

   // Show-ahead FIFO model: head word presented, popped on each pull.
   logic [31:0] fifo_mem [16];
   int          wr_ptr   = 0;
   int          rd_ptr   = 0;
   int          pull_cnt = 0;

   assign bus.i_fifo_empty       = (rd_ptr == wr_ptr);
   assign bus.i_fifo_pulled_data = fifo_mem[rd_ptr[3:0]];

   always @(posedge clk) begin
      if (bus.o_fifo_pull) begin
         rd_ptr   <= rd_ptr + 1;
         pull_cnt <= pull_cnt + 1;
      end
   end

   task automatic push(input logic [31:0] w);
      fifo_mem[wr_ptr[3:0]] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One strobe at minimum period (4 low, 2 high); output checked 3 edges after the fall.
   task automatic strobe(input logic [2:0] addr, input logic [7:0] exp, input string tag);
      @(negedge clk);
      bus.i_smi_a      = addr;
      bus.i_smi_soe_se = 1'b0;
      repeat (3) @(negedge clk);
      check(tag, {24'h0, bus.o_smi_data_out}, {24'h0, exp});
      @(negedge clk);
      bus.i_smi_soe_se = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int pulls_snap;

      bus.i_smi_a      = 3'b000;
      bus.i_smi_soe_se = 1'b1;
      for (int i = 0; i < 16; i++) fifo_mem[i] = 32'h0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_data", {24'h0, bus.o_smi_data_out}, 32'h0);
      check("rst_dreq", {31'h0, bus.o_smi_read_req}, 32'h0);
      check("rst_pull", {31'h0, bus.o_fifo_pull}, 32'h0);
      check("rst_underrun", {31'h0, underrun}, 32'h0);
      rst_n = 1'b1;

      // Single word: byte order, one pull, DREQ drop
      push(32'hA1B2C3D4);
      repeat (5) @(negedge clk);
      check("w1_dreq_hi", {31'h0, bus.o_smi_read_req}, 32'h1);
      strobe(3'b101, 8'hB2, "w1_b0");
      strobe(3'b101, 8'hA1, "w1_b1");
      strobe(3'b101, 8'hD4, "w1_b2");
      strobe(3'b101, 8'hC3, "w1_b3");
      check("w1_dreq_lo", {31'h0, bus.o_smi_read_req}, 32'h0);
      check("w1_pulls", pull_cnt, 32'd1);
      check("w1_underrun", {31'h0, underrun}, 32'h0);

      // Two words streamed at minimum strobe period
      push(32'h11223344);
      push(32'h55667788);
      repeat (5) @(negedge clk);
      strobe(3'b101, 8'h22, "w2_b0");
      strobe(3'b101, 8'h11, "w2_b1");
      strobe(3'b101, 8'h44, "w2_b2");
      strobe(3'b101, 8'h33, "w2_b3");
      strobe(3'b101, 8'h66, "w3_b0");
      strobe(3'b101, 8'h55, "w3_b1");
      strobe(3'b101, 8'h88, "w3_b2");
      strobe(3'b101, 8'h77, "w3_b3");
      check("w23_underrun", {31'h0, underrun}, 32'h0);
      check("w23_pulls", pull_cnt, 32'd3);

      // Underrun: zero byte, sticky flag, clear pulse
      strobe(3'b101, 8'h00, "ur_data");
      check("ur_set", {31'h0, underrun}, 32'h1);
      repeat (10) @(negedge clk);
      check("ur_held", {31'h0, underrun}, 32'h1);
      uclr = 1'b1;
      @(negedge clk);
      uclr = 1'b0;
      check("ur_clr", {31'h0, underrun}, 32'h0);

      // Clear coinciding with a new underrun: set wins
      @(negedge clk);
      bus.i_smi_a      = 3'b101;
      bus.i_smi_soe_se = 1'b0;
      repeat (2) @(negedge clk);
      uclr = 1'b1;
      @(negedge clk);
      uclr = 1'b0;
      check("ur_set_wins", {31'h0, underrun}, 32'h1);
      check("ur_set_wins_data", {24'h0, bus.o_smi_data_out}, 32'h0);
      @(negedge clk);
      bus.i_smi_soe_se = 1'b1;
      @(negedge clk);

      // Underrun did not skip anything: a new word starts at index 0
      push(32'hDEADBEEF);
      repeat (5) @(negedge clk);
      strobe(3'b101, 8'hAD, "post_ur_b0");
      strobe(3'b101, 8'hDE, "post_ur_b1");
      strobe(3'b101, 8'hEF, "post_ur_b2");
      strobe(3'b101, 8'hBE, "post_ur_b3");

      // Test mode: counter wraps, no pulls, DREQ forced low
      @(negedge clk);
      smi_test = 1'b1;
      push(32'hA1B2C3D4);
      pulls_snap = pull_cnt;
      for (int i = 0; i < 258; i++) strobe(3'b101, 8'(i), "test_cnt");
      check("test_dreq", {31'h0, bus.o_smi_read_req}, 32'h0);
      check("test_no_pull", pull_cnt, pulls_snap);
      smi_test = 1'b0;
      repeat (5) @(negedge clk);
      check("test_exit_pull", pull_cnt, pulls_snap + 1);
      check("test_exit_dreq", {31'h0, bus.o_smi_read_req}, 32'h1);

      // Address filtering: 3'b110 strobes leave everything untouched
      strobe(3'b110, 8'h01, "addr_ign0");
      strobe(3'b101, 8'hB2, "addr_b0");
      strobe(3'b110, 8'hB2, "addr_ign1");
      strobe(3'b101, 8'hA1, "addr_b1");
      strobe(3'b101, 8'hD4, "addr_b2");
      strobe(3'b110, 8'hD4, "addr_ign2");
      strobe(3'b101, 8'hC3, "addr_b3");

      // Asynchronous reset mid-word
      push(32'hA1B2C3D4);
      repeat (5) @(negedge clk);
      strobe(3'b101, 8'hB2, "rs_b0");
      strobe(3'b101, 8'hA1, "rs_b1");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rs_data", {24'h0, bus.o_smi_data_out}, 32'h0);
      check("rs_dreq", {31'h0, bus.o_smi_read_req}, 32'h0);
      check("rs_underrun", {31'h0, underrun}, 32'h0);
      check("rs_pull", {31'h0, bus.o_fifo_pull}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push(32'hCAFEF00D);
      repeat (5) @(negedge clk);
      check("rs_dreq_hi", {31'h0, bus.o_smi_read_req}, 32'h1);
      strobe(3'b101, 8'hFE, "rs_new_b0");
      strobe(3'b101, 8'hCA, "rs_new_b1");
      strobe(3'b101, 8'h0D, "rs_new_b2");
      strobe(3'b101, 8'hF0, "rs_new_b3");

      // Test counter restarts from zero after reset
      smi_test = 1'b1;
      strobe(3'b101, 8'h00, "test_cnt_rst");
      smi_test = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/smi_tx_serializer.md
# smi_tx_serializer

FPGA-to-host read path of the SMI link. Pulls 32-bit sample words from the 0.9 GHz RX FIFO and streams them to the Raspberry Pi as bytes, one byte per SMI read strobe (SOE). The byte order is the mirror of the SMI write-path assembler, so a host loopback returns identical words. The block runs entirely in the `i_sys_clk` domain: SMI strobes are synchronised, words are prefetched, and DREQ is driven to the host.

## Interface
- `P_READ_ADDR`, default 3'b101: SMI address the block responds to (read_900).
- `P_SYNC_STAGES`, default 2: synchroniser depth for `i_smi_soe_se`, legal values 2–3.
- `i_sys_clk`  in  1: FPGA system clock; all logic sits on its rising edge.
- `i_reset_n`  in  1: reset, asynchronous assert, active-low.
- `i_smi_a`  in  3: SMI address lines, sampled with the synchronised strobe.
- `i_smi_soe_se`  in  1: SMI read strobe from host, asynchronous, active-low.
- `i_smi_test`  in  1: 1 = emit an incrementing test counter instead of FIFO data.
- `o_fifo_pull`  out  1: one-cycle FIFO read request.
- `i_fifo_pulled_data`  in  32: FIFO read data, valid the cycle after `o_fifo_pull`.
- `i_fifo_empty`  in  1: FIFO empty flag.
- `o_smi_data_out`  out  8: byte presented on the SMI data bus.
- `o_smi_read_req`  out  1: DREQ, high while at least one unsent word is held.
- `i_underrun_clr`  in  1: one-cycle clear of `o_underrun`.
- `o_underrun`  out  1: sticky flag, set when a strobe found no data.

## Operation
- **Strobe detect:** `i_smi_soe_se` passes through `P_SYNC_STAGES` flops, then a falling-edge detector. A detected edge counts as a strobe only if `i_smi_a` (registered alongside it) equals `P_READ_ADDR`. Strobes at any other address are ignored and leave all state unchanged.
- **Storage:** two word registers.
  - ACTIVE: 32-bit word, valid bit, 2-bit byte index.
  - PREFETCH slot with states EMPTY → PENDING → FULL.
- **Prefetch FSM:**
  - EMPTY: if `!i_fifo_empty` and not in test mode, assert `o_fifo_pull` for one cycle and go to PENDING.
  - PENDING: on the next cycle, capture `i_fifo_pulled_data` and go to FULL.
  - FULL: when ACTIVE is invalid, or its last byte is consumed this cycle, move PREFETCH into ACTIVE with index 0, valid set, and go to EMPTY.
  - At most one pull is outstanding at a time.
- **Byte order:** for ACTIVE word W, index 0..3 outputs W[23:16], W[31:24], W[7:0], W[15:8]. The index wraps 3→0 and clears valid.
- **Strobe with ACTIVE valid:** register the indexed byte into `o_smi_data_out`, then advance the index.
- **Strobe with ACTIVE invalid (underrun):**
  - `o_smi_data_out` ← 8'h00 and `o_underrun` ← 1.
  - The index is not advanced and no word is skipped.
- **Test mode (`i_smi_test`=1):**
  - Each strobe outputs an 8-bit counter, then increments it; the counter wraps 8'hFF→8'h00.
  - No FIFO pulls are issued. ACTIVE and PREFETCH contents are held, not consumed.
  - The test counter resets only on reset.
- **DREQ:** `o_smi_read_req` is a registered copy of (ACTIVE valid OR PREFETCH FULL). It is forced to 0 in test mode.
- **Simultaneous events:**
  - Last-byte consume and PREFETCH FULL in the same cycle: hand-off in the same cycle, so the next strobe sees index 0 of the new word.
  - `i_underrun_clr` and a new underrun in the same cycle: set wins.
- **Reset:** any time, asynchronous.
  - All outputs go to 0: `o_smi_data_out`=8'h00, `o_fifo_pull`=0, `o_smi_read_req`=0, `o_underrun`=0.
  - Test counter=0, ACTIVE invalid with index 0, PREFETCH EMPTY, synchroniser flops=1 (strobe idle high).
  - A word pulled in PENDING is lost; the host must re-flush after reset.

## Timing
- Strobe latency: SOE falling edge → `o_smi_data_out` updated after `P_SYNC_STAGES`+1 `i_sys_clk` edges (3 by default).
- Host strobe timing requirements: strobe low time ≥ `P_SYNC_STAGES`+2 cycles; strobe period ≥ 2×(`P_SYNC_STAGES`+1) cycles.
- FIFO: `o_fifo_pull` → data captured exactly 1 cycle later.
- Refill: EMPTY → FULL takes 2 cycles, which is shorter than four minimum strobe periods. Sustained streaming therefore never underruns while the FIFO is non-empty.
- DREQ: 1 cycle after the underlying condition changes.

## Structure
- Package `smi_pkg`:
  - SMI address constants (idle, write_900, write_2400, read_900, read_2400).
  - Byte-order constants for index→byte-lane mapping, shared with the write-path assembler.
  - Prefetch state enum.
- Sub-module `smi_strobe_sync`: N-stage synchroniser plus falling-edge pulse, reset to 1. It will be reused for SWE when the write path moves into the `i_sys_clk` domain.

## Test plan
- FIFO holds 32'hA1B2C3D4, four strobes at 3'b101 → bytes B2, A1, D4, C3; a single `o_fifo_pull` pulse; DREQ 1 → 0 after the 4th strobe; `o_underrun`=0.
- FIFO holds 32'h11223344 and 32'h55667788, eight strobes at minimum period → 22 11 44 33 66 55 88 77 with no underrun.
- FIFO empty, one strobe → 8'h00 and `o_underrun`=1, held until an `i_underrun_clr` pulse; clr and underrun in the same cycle → flag stays 1.
- `i_smi_test`=1, 258 strobes → 00, 01, … FF, 00, 01; `o_fifo_pull` never asserted; DREQ=0.
- Word 32'hA1B2C3D4, strobes interleaved at 3'b110 and 3'b101 → 3'b110 strobes ignored, 3'b101 strobes yield B2, A1, D4, C3.
- `i_reset_n` pulsed low after the 2nd byte → outputs go to 0 immediately. After release, the FIFO next word 32'hCAFEF00D is sent as FE, CA, 0D, F0.
